// File: rtl/spi_pkg.sv
// Shared types and frame constants for the SPI ROM master.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_FLUSH,
    ST_DONE
  } spi_mst_state_t;

  // Frame layout as seen by the sck-domain ROM slave, in rising-edge numbers.
  localparam logic [4:0] SPI_DUMMY_EDGES     = 5'd1;
  localparam logic [4:0] SPI_ADDR_BITS       = 5'd5;
  localparam logic [4:0] SPI_FIRST_DATA_EDGE = 5'd9;
  localparam logic [4:0] SPI_FRAME_EDGES     = 5'd24;

endpackage

// File: rtl/spi_sck_gen.sv
// Phase timer for the serial clock: marks the last clk cycle of each
// CLK_DIV-long sck phase and reports whether that boundary is a rise or a fall.
module spi_sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic sck_level,
  output logic rise,
  output logic fall
);

  localparam int PW = $clog2(CLK_DIV + 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] phase_cnt;
  logic          phase_end;

  assign phase_end = en && (phase_cnt == PHASE_LAST);
  assign rise      = phase_end && !sck_level;
  assign fall      = phase_end && sck_level;

  // Count clk cycles within the current phase; restart at each phase boundary or when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_cnt <= '0;
    end else if (!en || phase_end) begin
      phase_cnt <= '0;
    end else begin
      phase_cnt <= phase_cnt + PW'(1);
    end
  end

endmodule

// File: rtl/spi_rom_master.sv
// SPI mode-0 master issuing single-word read frames to the sck-domain ROM slave.
// Every frame ends with one sck rising edge while cs_n is high, which is the only
// way the slave's bit counter is reset; the same flush runs once after reset.
module spi_rom_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              spi_sck,
  output logic              spi_cs_n,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  spi_mst_state_t    state;
  logic [4:0]        edge_cnt;
  logic [ADDR_W-1:0] addr_sh;
  logic [DATA_W-1:0] data_sh;
  logic              gen_en;
  logic              rise;
  logic              fall;

  assign req_ready = (state == ST_IDLE);

  // The phase timer only runs while sck is being generated.
  always_comb begin
    gen_en = 1'b0;
    case (state)
      ST_INIT, ST_SETUP, ST_SHIFT, ST_FLUSH: gen_en = 1'b1;
      default:                               gen_en = 1'b0;
    endcase
  end

  spi_sck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sck_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (gen_en),
    .sck_level (spi_sck),
    .rise      (rise),
    .fall      (fall)
  );

  // Frame sequencer: drives sck/cs_n/mosi, counts rising edges, captures miso.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      spi_sck   <= 1'b0;
      spi_cs_n  <= 1'b1;
      spi_mosi  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      edge_cnt  <= '0;
      addr_sh   <= '0;
      data_sh   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        // Flush: low, one rising edge with cs_n high, high, low, then move on.
        // edge_cnt marks whether the single flush edge has already been made.
        ST_INIT, ST_FLUSH: begin
          if (rise) begin
            if (edge_cnt == 5'd0) begin
              spi_sck  <= 1'b1;
              edge_cnt <= 5'd1;
            end else begin
              edge_cnt <= 5'd0;
              state    <= (state == ST_INIT) ? ST_IDLE : ST_DONE;
            end
          end else if (fall) begin
            spi_sck <= 1'b0;
          end
        end

        ST_IDLE: begin
          if (req_valid) begin
            addr_sh  <= req_addr;
            spi_cs_n <= 1'b0;
            state    <= ST_SETUP;
          end
        end

        // End of the setup low phase produces rising edge 1 (the slave's dummy edge).
        ST_SETUP: begin
          if (rise) begin
            spi_sck  <= 1'b1;
            edge_cnt <= 5'd1;
            state    <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (rise) begin
            if (edge_cnt == SPI_FRAME_EDGES) begin
              // Last low phase is over: release the slave and flush it.
              spi_cs_n <= 1'b1;
              edge_cnt <= 5'd0;
              state    <= ST_FLUSH;
            end else begin
              spi_sck  <= 1'b1;
              edge_cnt <= edge_cnt + 5'd1;
              // miso still holds the bit the slave presented during the low phase.
              if ((edge_cnt + 5'd1) >= SPI_FIRST_DATA_EDGE) begin
                data_sh <= {data_sh[DATA_W-2:0], spi_miso};
              end
            end
          end else if (fall) begin
            spi_sck <= 1'b0;
            // Address bits go out in the low phases ahead of edges 2..6.
            if ((edge_cnt >= SPI_DUMMY_EDGES) &&
                (edge_cnt < (SPI_DUMMY_EDGES + SPI_ADDR_BITS))) begin
              spi_mosi <= addr_sh[ADDR_W-1];
              addr_sh  <= {addr_sh[ADDR_W-2:0], 1'b0};
            end else begin
              spi_mosi <= 1'b0;
            end
          end
        end

        ST_DONE: begin
          rsp_valid <= 1'b1;
          rsp_data  <= data_sh;
          state     <= ST_IDLE;
        end

        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_rom_master.sv
// Bench: two masters (CLK_DIV=4 and CLK_DIV=1), each wired to a behavioural
// SPI ROM slave with mem[a] = 16'hA500 | a.
module tb_spi_rom_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Instance 0: CLK_DIV = 4
  logic        req_valid, req_ready, rsp_valid;
  logic [4:0]  req_addr;
  logic [15:0] rsp_data;
  logic        sck, cs_n, mosi, miso;

  // Instance 1: CLK_DIV = 1
  logic        req_valid1, req_ready1, rsp_valid1;
  logic [4:0]  req_addr1;
  logic [15:0] rsp_data1;
  logic        sck1, cs_n1, mosi1, miso1;

  int n_pass  = 0;
  int n_total = 0;

  spi_rom_master #(.CLK_DIV(4), .ADDR_W(5), .DATA_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .spi_sck(sck), .spi_cs_n(cs_n), .spi_mosi(mosi), .spi_miso(miso)
  );

  spi_rom_master #(.CLK_DIV(1), .ADDR_W(5), .DATA_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid1), .req_addr(req_addr1), .req_ready(req_ready1),
    .rsp_valid(rsp_valid1), .rsp_data(rsp_data1),
    .spi_sck(sck1), .spi_cs_n(cs_n1), .spi_mosi(mosi1), .spi_miso(miso1)
  );

  // ---------------- slave model 0 ----------------
  int          s0_cnt = 0;
  logic [4:0]  s0_addr = 5'd0;
  logic [15:0] s0_sh = 16'd0;
  int          flush0 = 0, edges0 = 0, stray0 = 0, rsp_cnt0 = 0;
  assign miso = s0_sh[15];

  always @(posedge sck) begin
    if (cs_n) begin
      s0_cnt = 0; s0_sh = 16'd0; flush0++;
    end else begin
      s0_cnt++; edges0++;
      if (s0_cnt >= 2 && s0_cnt <= 6) s0_addr = {s0_addr[3:0], mosi};
      else begin
        if (mosi) stray0++;
        if (s0_cnt == 8) s0_sh = 16'hA500 | {11'd0, s0_addr};
        else if (s0_cnt >= 9 && s0_cnt <= 24) s0_sh = {s0_sh[14:0], 1'b0};
      end
    end
  end

  always @(posedge clk) if (rsp_valid) rsp_cnt0++;

  // ---------------- slave model 1 ----------------
  int          s1_cnt = 0;
  logic [4:0]  s1_addr = 5'd0;
  logic [15:0] s1_sh = 16'd0;
  int          edges1 = 0, stray1 = 0;
  assign miso1 = s1_sh[15];

  always @(posedge sck1) begin
    if (cs_n1) begin
      s1_cnt = 0; s1_sh = 16'd0;
    end else begin
      s1_cnt++; edges1++;
      if (s1_cnt >= 2 && s1_cnt <= 6) s1_addr = {s1_addr[3:0], mosi1};
      else begin
        if (mosi1) stray1++;
        if (s1_cnt == 8) s1_sh = 16'hA500 | {11'd0, s1_addr};
        else if (s1_cnt >= 9 && s1_cnt <= 24) s1_sh = {s1_sh[14:0], 1'b0};
      end
    end
  end

  // Issue one read on instance 0 (call at a negedge); returns at the negedge where
  // rsp_valid is high. wait_cyc = cycles waited for ready, lat = edges after accept (-1 on timeout).
  task automatic do_read(input logic [4:0] a, output int wait_cyc, output int lat);
    req_valid = 1'b1; req_addr = a; wait_cyc = 0; lat = -1;
    while (!req_ready && wait_cyc < 2000) begin @(negedge clk); wait_cyc++; end
    if (!req_ready) begin req_valid = 1'b0; return; end
    @(posedge clk); lat = 0;
    @(negedge clk); req_valid = 1'b0;
    while (!rsp_valid && lat < 2000) begin @(posedge clk); lat++; @(negedge clk); end
    if (!rsp_valid) lat = -1;
    $display("read addr=%h data=%h latency=%0d", a, rsp_data, lat);
  endtask

  task automatic test_reset_and_first_read();
    int w, lat, c;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = 5'd0;
    req_valid1 = 1'b0; req_addr1 = 5'd0;
    repeat (3) @(negedge clk);
    n_total++; if (cs_n !== 1'b1) $display("FAIL rst_cs_n: got %b expected 1", cs_n); else n_pass++;
    n_total++; if (sck !== 1'b0) $display("FAIL rst_sck: got %b expected 0", sck); else n_pass++;
    n_total++; if (mosi !== 1'b0) $display("FAIL rst_mosi: got %b expected 0", mosi); else n_pass++;
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); else n_pass++;
    n_total++; if (rsp_data !== 16'h0000) $display("FAIL rst_rsp_data: got %h expected 0000", rsp_data); else n_pass++;
    n_total++; if (req_ready !== 1'b0) $display("FAIL rst_req_ready: got %b expected 0", req_ready); else n_pass++;
    flush0 = 0; edges0 = 0;
    rst_n = 1'b1;
    c = 0;
    while (!req_ready && c < 500) begin @(negedge clk); c++; end
    n_total++; if (!req_ready) $display("FAIL init_ready: got 0 expected 1 within 500 cycles"); else n_pass++;
    n_total++; if (flush0 !== 1) $display("FAIL init_flush: got %0d flush edges expected 1", flush0); else n_pass++;
    n_total++; if (edges0 !== 0) $display("FAIL init_cs_edges: got %0d expected 0", edges0); else n_pass++;
    edges0 = 0; flush0 = 0; stray0 = 0;
    do_read(5'h03, w, lat);
    n_total++; if (lat !== 209) $display("FAIL r03_latency: got %0d expected 209", lat); else n_pass++;
    n_total++; if (rsp_data !== 16'hA503) $display("FAIL r03_data: got %h expected a503", rsp_data); else n_pass++;
    n_total++; if (edges0 !== 24) $display("FAIL r03_edges: got %0d expected 24", edges0); else n_pass++;
    n_total++; if (flush0 !== 1) $display("FAIL r03_flush: got %0d expected 1", flush0); else n_pass++;
    n_total++; if (s0_addr !== 5'h03) $display("FAIL r03_slave_addr: got %h expected 03", s0_addr); else n_pass++;
    n_total++; if (stray0 !== 0) $display("FAIL r03_mosi_idle: got %0d stray ones expected 0", stray0); else n_pass++;
    @(negedge clk);
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL r03_pulse: got %b expected 0", rsp_valid); else n_pass++;
    n_total++; if (rsp_data !== 16'hA503) $display("FAIL r03_hold: got %h expected a503", rsp_data); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int w, lat;
    edges0 = 0; flush0 = 0;
    do_read(5'h00, w, lat);
    n_total++; if (rsp_data !== 16'hA500) $display("FAIL b2b0_data: got %h expected a500", rsp_data); else n_pass++;
    n_total++; if (lat !== 209) $display("FAIL b2b0_latency: got %0d expected 209", lat); else n_pass++;
    n_total++; if (flush0 !== 1) $display("FAIL b2b_gap_flush: got %0d expected 1", flush0); else n_pass++;
    edges0 = 0; flush0 = 0;
    do_read(5'h1F, w, lat);
    n_total++; if (w !== 0) $display("FAIL b2b_gap: got %0d wait cycles expected 0", w); else n_pass++;
    n_total++; if (rsp_data !== 16'hA51F) $display("FAIL b2b1_data: got %h expected a51f", rsp_data); else n_pass++;
    n_total++; if (edges0 !== 24) $display("FAIL b2b1_edges: got %0d expected 24", edges0); else n_pass++;
    n_total++; if (lat !== 209) $display("FAIL b2b1_latency: got %0d expected 209", lat); else n_pass++;
  endtask

  task automatic test_busy_ignore();
    int c, lat, busy_acc;
    busy_acc = 0;
    req_valid = 1'b1; req_addr = 5'h07; c = 0;
    while (!req_ready && c < 500) begin @(negedge clk); c++; end
    @(posedge clk); lat = 0;
    @(negedge clk);
    while (!rsp_valid && lat < 2000) begin
      req_addr = 5'(lat * 7 + 3);
      if (req_ready) busy_acc++;
      @(posedge clk); lat++; @(negedge clk);
    end
    $display("read addr=07 data=%h latency=%0d (req_valid held)", rsp_data, lat);
    n_total++; if (busy_acc !== 0) $display("FAIL busy_ready: got %0d ready cycles expected 0", busy_acc); else n_pass++;
    n_total++; if (rsp_data !== 16'hA507) $display("FAIL busy_data: got %h expected a507", rsp_data); else n_pass++;
    n_total++; if (lat !== 209) $display("FAIL busy_latency: got %0d expected 209", lat); else n_pass++;
    // Still valid: the next request goes in the cycle right after DONE.
    req_addr = 5'h19;
    @(posedge clk); lat = 0;
    @(negedge clk);
    n_total++; if (req_ready !== 1'b0) $display("FAIL busy_second_accept: got ready %b expected 0", req_ready); else n_pass++;
    req_valid = 1'b0;
    while (!rsp_valid && lat < 2000) begin @(posedge clk); lat++; @(negedge clk); end
    $display("read addr=19 data=%h latency=%0d", rsp_data, lat);
    n_total++; if (rsp_data !== 16'hA519) $display("FAIL busy2_data: got %h expected a519", rsp_data); else n_pass++;
    n_total++; if (lat !== 209) $display("FAIL busy2_latency: got %0d expected 209", lat); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int c, w, lat;
    edges0 = 0;
    req_valid = 1'b1; req_addr = 5'h1C; c = 0;
    while (!req_ready && c < 500) begin @(negedge clk); c++; end
    @(posedge clk); @(negedge clk); req_valid = 1'b0;
    c = 0;
    while (edges0 < 12 && c < 500) begin @(negedge clk); c++; end
    n_total++; if (edges0 !== 12) $display("FAIL mid_edge12: got %0d expected 12", edges0); else n_pass++;
    rsp_cnt0 = 0;
    rst_n = 1'b0;
    #1;
    n_total++; if (cs_n !== 1'b1) $display("FAIL mid_cs_n: got %b expected 1", cs_n); else n_pass++;
    n_total++; if (sck !== 1'b0) $display("FAIL mid_sck: got %b expected 0", sck); else n_pass++;
    n_total++; if (rsp_data !== 16'h0000) $display("FAIL mid_rsp_data: got %h expected 0000", rsp_data); else n_pass++;
    n_total++; if (req_ready !== 1'b0) $display("FAIL mid_ready: got %b expected 0", req_ready); else n_pass++;
    @(negedge clk); @(negedge clk);
    flush0 = 0;
    rst_n = 1'b1;
    c = 0;
    while (!req_ready && c < 500) begin @(negedge clk); c++; end
    $display("reset at edge 12, reinit took %0d cycles", c);
    n_total++; if (flush0 !== 1) $display("FAIL mid_init_flush: got %0d expected 1", flush0); else n_pass++;
    n_total++; if (rsp_cnt0 !== 0) $display("FAIL mid_no_rsp: got %0d responses expected 0", rsp_cnt0); else n_pass++;
    do_read(5'h0A, w, lat);
    n_total++; if (rsp_data !== 16'hA50A) $display("FAIL mid_read_data: got %h expected a50a", rsp_data); else n_pass++;
    n_total++; if (lat !== 209) $display("FAIL mid_read_latency: got %0d expected 209", lat); else n_pass++;
  endtask

  task automatic test_clk_div1();
    int c, lat;
    c = 0;
    while (!req_ready1 && c < 500) begin @(negedge clk); c++; end
    edges1 = 0; stray1 = 0;
    req_valid1 = 1'b1; req_addr1 = 5'h15;
    @(posedge clk); lat = 0;
    @(negedge clk); req_valid1 = 1'b0;
    while (!rsp_valid1 && lat < 500) begin @(posedge clk); lat++; @(negedge clk); end
    $display("div1 read addr=15 data=%h latency=%0d", rsp_data1, lat);
    n_total++; if (lat !== 53) $display("FAIL div1_latency: got %0d expected 53", lat); else n_pass++;
    n_total++; if (rsp_data1 !== 16'hA515) $display("FAIL div1_data: got %h expected a515", rsp_data1); else n_pass++;
    n_total++; if (s1_addr !== 5'h15) $display("FAIL div1_mosi_pattern: got %b expected 10101", s1_addr); else n_pass++;
    n_total++; if (stray1 !== 0) $display("FAIL div1_mosi_idle: got %0d stray ones expected 0", stray1); else n_pass++;
    n_total++; if (edges1 !== 24) $display("FAIL div1_edges: got %0d expected 24", edges1); else n_pass++;
  endtask

  initial begin
    test_reset_and_first_read();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_frame();
    test_clk_div1();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
